spi_reg_slave: RTL and testbench

SPI_REG_SLAVE -- requirements
Module: spi_reg_slave

---
 rtl/spi_reg_slave_if.sv | 14 +
 rtl/spi_reg_slave.sv | 217 +++++++++++++++++++++
 tb/tb_spi_reg_slave.sv | 224 ++++++++++++++++++++++
 3 files changed

// File: rtl/spi_reg_slave_if.sv
// SPI pin bundle between an SPI master and spi_reg_slave.
//   SCLK : SPI clock from the master (asynchronous to the slave's clk)
//   SS   : active-low slave select
//   MOSI : master-out serial data
//   MISO : slave-out serial data, always driven
interface spi_reg_slave_if;
  logic SCLK;
  logic SS;
  logic MOSI;
  logic MISO;

  modport master (output SCLK, output SS, output MOSI, input MISO);
  modport slave  (input SCLK, input SS, input MOSI, output MISO);
endinterface

// File: rtl/spi_reg_slave.sv
// SPI mode-0 register slave: 16-bit frames of {command, data} access an 8 x 8 register file.
// During the command byte MISO returns the completed-frame counter; during the data byte
// it returns the addressed register (read-before-write on writes).
//   clk        : system clock
//   btn_reset  : synchronous active-high reset
//   spi        : SPI pins (SCLK, SS, MOSI in; MISO out)
//   leds       : registered copy of register 0
//   is_busy    : high while a frame is in progress
//   frame_done : one-clk pulse per accepted 16-bit frame
module spi_reg_slave #(
  parameter int unsigned SYNC_STAGES = 2
) (
  input  logic              clk,
  input  logic              btn_reset,
  spi_reg_slave_if.slave    spi,
  output logic [7:0]        leds,
  output logic              is_busy,
  output logic              frame_done
);

  localparam int unsigned DATA_W   = 8;
  localparam int unsigned ADDR_W   = 3;
  localparam int unsigned NUM_REGS = 8;
  localparam int unsigned CNT_W    = 4;

  typedef enum logic [1:0] {IDLE, CMD, DATA, WAIT_SS} state_t;

  state_t                               r_state;
  state_t                               w_state_nxt;
  logic [SYNC_STAGES-1:0]               r_sclk_sync;
  logic [SYNC_STAGES-1:0]               r_ss_sync;
  logic [SYNC_STAGES-1:0]               r_mosi_sync;
  logic [SYNC_STAGES:0]                 w_sclk_chain;
  logic [SYNC_STAGES:0]                 w_ss_chain;
  logic [SYNC_STAGES:0]                 w_mosi_chain;
  logic                                 w_sclk_s, w_ss_s, w_mosi_s;
  logic                                 r_sclk_d, r_ss_d;
  logic                                 w_sclk_rise, w_sclk_fall, w_ss_fall;
  logic [NUM_REGS-1:0][DATA_W-1:0]      r_regs;
  logic [DATA_W-1:0]                    r_frame_count;
  logic [DATA_W-1:0]                    r_rx;
  logic [DATA_W-2:0]                    r_tx;
  logic [CNT_W-1:0]                     r_bit_cnt;
  logic                                 r_is_write;
  logic [ADDR_W-1:0]                    r_addr;
  logic                                 r_miso;
  logic [DATA_W-1:0]                    r_leds;
  logic                                 r_busy;
  logic                                 r_frame_done;
  logic                                 w_start, w_rise_en, w_cmd_done, w_frame_end;
  logic                                 w_tx_shift, w_tx_load_reg;
  logic                                 w_miso_nxt;
  logic [DATA_W-1:0]                    w_rx_byte;

  // Synchronizer chains: index 0 is the raw pin, the top index is the synchronized copy.
  assign w_sclk_chain = {r_sclk_sync, spi.SCLK};
  assign w_ss_chain   = {r_ss_sync,   spi.SS};
  assign w_mosi_chain = {r_mosi_sync, spi.MOSI};
  assign w_sclk_s     = w_sclk_chain[SYNC_STAGES];
  assign w_ss_s       = w_ss_chain[SYNC_STAGES];
  assign w_mosi_s     = w_mosi_chain[SYNC_STAGES];

  // SCLK and SS edges, seen in the clk domain.
  assign w_sclk_rise  = w_sclk_s & ~r_sclk_d;
  assign w_sclk_fall  = ~w_sclk_s & r_sclk_d;
  assign w_ss_fall    = r_ss_d & ~w_ss_s;

  assign w_rx_byte    = {r_rx[DATA_W-2:0], w_mosi_s};

  // Next-state and control strobes.
  always_comb begin
    w_state_nxt   = r_state;
    w_start       = 1'b0;
    w_rise_en     = 1'b0;
    w_cmd_done    = 1'b0;
    w_frame_end   = 1'b0;
    w_tx_shift    = 1'b0;
    w_tx_load_reg = 1'b0;
    w_miso_nxt    = r_miso;
    case (r_state)
      IDLE: begin
        w_miso_nxt = 1'b0;
        if (w_ss_fall) begin
          w_state_nxt = CMD;
          w_start     = 1'b1;
          w_miso_nxt  = r_frame_count[DATA_W-1];
        end
      end
      CMD: begin
        if (w_ss_s) begin
          w_state_nxt = IDLE;
          w_miso_nxt  = 1'b0;
        end else begin
          if (w_sclk_rise) begin
            w_rise_en = 1'b1;
            if (r_bit_cnt == CNT_W'(7)) begin
              w_state_nxt = DATA;
              w_cmd_done  = 1'b1;
            end
          end
          if (w_sclk_fall) begin
            w_tx_shift = 1'b1;
            w_miso_nxt = r_tx[DATA_W-2];
          end
        end
      end
      DATA: begin
        if (w_ss_s) begin
          w_state_nxt = IDLE;
          w_miso_nxt  = 1'b0;
        end else begin
          if (w_sclk_rise) begin
            w_rise_en = 1'b1;
            if (r_bit_cnt == CNT_W'(15)) begin
              w_state_nxt = WAIT_SS;
              w_frame_end = 1'b1;
            end
          end
          // First falling edge of the data byte loads the addressed register.
          if (w_sclk_fall) begin
            if (r_bit_cnt == CNT_W'(8)) begin
              w_tx_load_reg = 1'b1;
              w_miso_nxt    = r_regs[r_addr][DATA_W-1];
            end else begin
              w_tx_shift = 1'b1;
              w_miso_nxt = r_tx[DATA_W-2];
            end
          end
        end
      end
      WAIT_SS: begin
        w_miso_nxt = 1'b0;
        if (w_ss_s) begin
          w_state_nxt = IDLE;
        end
      end
      default: begin
        w_state_nxt = IDLE;
        w_miso_nxt  = 1'b0;
      end
    endcase
  end

  // State register.
  always_ff @(posedge clk) begin
    if (btn_reset) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // Synchronizers, shifters, register file and registered outputs.
  always_ff @(posedge clk) begin
    if (btn_reset) begin
      r_sclk_sync   <= '0;
      r_ss_sync     <= '0;
      r_mosi_sync   <= '0;
      r_sclk_d      <= 1'b0;
      r_ss_d        <= 1'b0;
      r_regs        <= '0;
      r_frame_count <= '0;
      r_rx          <= '0;
      r_tx          <= '0;
      r_bit_cnt     <= '0;
      r_is_write    <= 1'b0;
      r_addr        <= '0;
      r_miso        <= 1'b0;
      r_leds        <= '0;
      r_busy        <= 1'b0;
      r_frame_done  <= 1'b0;
    end else begin
      r_sclk_sync  <= w_sclk_chain[SYNC_STAGES-1:0];
      r_ss_sync    <= w_ss_chain[SYNC_STAGES-1:0];
      r_mosi_sync  <= w_mosi_chain[SYNC_STAGES-1:0];
      r_sclk_d     <= w_sclk_s;
      r_ss_d       <= w_ss_s;
      r_miso       <= w_miso_nxt;
      r_busy       <= (w_state_nxt != IDLE);
      r_frame_done <= w_frame_end;
      r_leds       <= r_regs[0];

      if (w_start) begin
        r_bit_cnt <= '0;
        r_rx      <= '0;
        r_tx      <= r_frame_count[DATA_W-2:0];
      end
      if (w_rise_en) begin
        r_rx      <= w_rx_byte;
        r_bit_cnt <= r_bit_cnt + CNT_W'(1);
      end
      if (w_cmd_done) begin
        r_is_write <= w_rx_byte[DATA_W-1];
        r_addr     <= w_rx_byte[ADDR_W-1:0];
      end
      if (w_tx_shift) begin
        r_tx <= {r_tx[DATA_W-3:0], 1'b0};
      end
      if (w_tx_load_reg) begin
        r_tx <= r_regs[r_addr][DATA_W-2:0];
      end
      // Commit becomes visible on the cycle after the 16th rising edge, with frame_done.
      if (w_frame_end) begin
        r_frame_count <= r_frame_count + DATA_W'(1);
        if (r_is_write) begin
          r_regs[r_addr] <= w_rx_byte;
        end
      end
    end
  end

  assign spi.MISO  = r_miso;
  assign leds      = r_leds;
  assign is_busy   = r_busy;
  assign frame_done = r_frame_done;

endmodule

// File: tb/tb_spi_reg_slave.sv
// Directed bench for spi_reg_slave: a table of full frames plus hand-written
// sequences for abort, overrun, mid-frame reset and frame-counter wrap.
module tb_spi_reg_slave;

  localparam int unsigned SYNC = 2;
  localparam int HALF = 6;

  logic       clk;
  logic       btn_reset;
  logic [7:0] leds;
  logic       is_busy;
  logic       frame_done;

  spi_reg_slave_if spi_bus ();

  spi_reg_slave #(.SYNC_STAGES(SYNC)) dut (
    .clk        (clk),
    .btn_reset  (btn_reset),
    .spi        (spi_bus),
    .leds       (leds),
    .is_busy    (is_busy),
    .frame_done (frame_done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_vec  = 0;
  int n_fail = 0;
  int done_cnt = 0;

  always @(negedge clk) begin
    if (frame_done === 1'b1) done_cnt++;
  end

  typedef struct {
    logic       pre_reset;
    logic [7:0] b0;
    logic [7:0] b1;
    logic [7:0] exp_m0;
    logic [7:0] exp_m1;
    logic [7:0] exp_leds;
  } vec_t;

  vec_t vecs [8];

  task automatic wait_clk(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic do_reset();
    btn_reset = 1'b1;
    wait_clk(3);
    check("rst_miso", 32'(spi_bus.MISO), 32'h0);
    check("rst_leds", 32'(leds), 32'h0);
    check("rst_busy", 32'(is_busy), 32'h0);
    check("rst_done", 32'(frame_done), 32'h0);
    btn_reset = 1'b0;
    wait_clk(3);
  endtask

  // Drives SS low and n_rise SCLK cycles of {b0,b1}, then n_extra more SCLK cycles
  // while counting non-zero MISO samples. Leaves SS low.
  task automatic spi_frame(input logic [7:0] b0, input logic [7:0] b1, input int n_rise,
                           input int n_extra, output logic [7:0] m0, output logic [7:0] m1,
                           output int extra_bad);
    logic [15:0] tx;
    logic [15:0] rx;
    tx = {b0, b1};
    rx = '0;
    extra_bad = 0;
    spi_bus.SS = 1'b0;
    for (int i = 0; i < n_rise; i++) begin
      spi_bus.MOSI = tx[15-i];
      wait_clk(HALF);
      rx[15-i] = spi_bus.MISO;
      spi_bus.SCLK = 1'b1;
      wait_clk(HALF);
      spi_bus.SCLK = 1'b0;
    end
    for (int j = 0; j < n_extra; j++) begin
      wait_clk(HALF);
      if (spi_bus.MISO !== 1'b0) extra_bad++;
      spi_bus.SCLK = 1'b1;
      wait_clk(HALF);
      if (spi_bus.MISO !== 1'b0) extra_bad++;
      spi_bus.SCLK = 1'b0;
    end
    wait_clk(HALF);
    m0 = rx[15:8];
    m1 = rx[7:0];
  endtask

  task automatic ss_release();
    spi_bus.SS = 1'b1;
    wait_clk(8);
  endtask

  initial begin
    #2ms;
    $display("FAIL watchdog: simulation did not finish, expected completion");
    $fatal(1);
  end

  initial begin
    logic [7:0] m0, m1;
    int bad, d0, k;

    vecs[0] = '{1'b1, 8'h80, 8'h5A, 8'h00, 8'h00, 8'h5A};
    vecs[1] = '{1'b1, 8'h83, 8'hC3, 8'h00, 8'h00, 8'h00};
    vecs[2] = '{1'b0, 8'h03, 8'h00, 8'h01, 8'hC3, 8'h00};
    vecs[3] = '{1'b0, 8'hF8, 8'hA5, 8'h02, 8'h00, 8'hA5};
    vecs[4] = '{1'b0, 8'h78, 8'h00, 8'h03, 8'hA5, 8'hA5};
    vecs[5] = '{1'b0, 8'h87, 8'h3C, 8'h04, 8'h00, 8'hA5};
    vecs[6] = '{1'b0, 8'h07, 8'hFF, 8'h05, 8'h3C, 8'hA5};
    vecs[7] = '{1'b0, 8'h03, 8'h00, 8'h06, 8'hC3, 8'hA5};

    btn_reset    = 1'b1;
    spi_bus.SS   = 1'b1;
    spi_bus.SCLK = 1'b0;
    spi_bus.MOSI = 1'b0;
    wait_clk(2);

    // Full frames from the table; frame counter is 7 afterwards.
    for (int v = 0; v < 8; v++) begin
      if (vecs[v].pre_reset) do_reset();
      d0 = done_cnt;
      spi_frame(vecs[v].b0, vecs[v].b1, 16, 0, m0, m1, bad);
      ss_release();
      check($sformatf("v%0d_miso0", v), 32'(m0), 32'(vecs[v].exp_m0));
      check($sformatf("v%0d_miso1", v), 32'(m1), 32'(vecs[v].exp_m1));
      check($sformatf("v%0d_leds", v), 32'(leds), 32'(vecs[v].exp_leds));
      check($sformatf("v%0d_done", v), 32'(done_cnt - d0), 32'd1);
    end

    // Abort after 11 rising edges of a write to reg1.
    d0 = done_cnt;
    spi_frame(8'h81, 8'hFF, 11, 0, m0, m1, bad);
    check("abort_miso0", 32'(m0), 32'h07);
    check("abort_busy_hi", 32'(is_busy), 32'h1);
    spi_bus.SS = 1'b1;
    k = 0;
    while (is_busy !== 1'b0 && k < int'(SYNC) + 2) begin
      @(negedge clk);
      k++;
    end
    check("abort_busy_lo", 32'(is_busy), 32'h0);
    wait_clk(8);
    check("abort_done", 32'(done_cnt - d0), 32'd0);
    d0 = done_cnt;
    spi_frame(8'h01, 8'h00, 16, 0, m0, m1, bad);
    ss_release();
    check("abort_rd_miso0", 32'(m0), 32'h07);
    check("abort_rd_reg1", 32'(m1), 32'h00);
    check("abort_rd_done", 32'(done_cnt - d0), 32'd1);

    // 20 extra SCLK cycles after a write to reg2.
    d0 = done_cnt;
    spi_frame(8'h82, 8'h77, 16, 20, m0, m1, bad);
    check("extra_miso0", 32'(m0), 32'h08);
    check("extra_miso_zero", 32'(bad), 32'd0);
    ss_release();
    check("extra_done", 32'(done_cnt - d0), 32'd1);
    spi_frame(8'h02, 8'h00, 16, 0, m0, m1, bad);
    ss_release();
    check("extra_rd_miso0", 32'(m0), 32'h09);
    check("extra_rd_reg2", 32'(m1), 32'h77);

    // Reset during byte1 of a write to reg0; leds currently 0xA5.
    d0 = done_cnt;
    spi_frame(8'h80, 8'h11, 12, 0, m0, m1, bad);
    check("mrst_miso0", 32'(m0), 32'h0A);
    btn_reset = 1'b1;
    wait_clk(2);
    check("mrst_in_miso", 32'(spi_bus.MISO), 32'h0);
    check("mrst_in_leds", 32'(leds), 32'h0);
    check("mrst_in_busy", 32'(is_busy), 32'h0);
    check("mrst_in_done", 32'(frame_done), 32'h0);
    btn_reset = 1'b0;
    bad = 0;
    for (int i = 0; i < 4; i++) begin
      spi_bus.MOSI = 1'b1;
      wait_clk(HALF);
      if (spi_bus.MISO !== 1'b0 || is_busy !== 1'b0) bad++;
      spi_bus.SCLK = 1'b1;
      wait_clk(HALF);
      if (spi_bus.MISO !== 1'b0 || is_busy !== 1'b0) bad++;
      spi_bus.SCLK = 1'b0;
    end
    check("mrst_after_idle", 32'(bad), 32'd0);
    ss_release();
    check("mrst_leds", 32'(leds), 32'h00);
    check("mrst_no_done", 32'(done_cnt - d0), 32'd0);
    d0 = done_cnt;
    spi_frame(8'h80, 8'h11, 16, 0, m0, m1, bad);
    ss_release();
    check("mrst_next_miso0", 32'(m0), 32'h00);
    check("mrst_next_miso1", 32'(m1), 32'h00);
    check("mrst_next_leds", 32'(leds), 32'h11);
    check("mrst_next_done", 32'(done_cnt - d0), 32'd1);

    // 257 reads from reset: the counter wraps back to 0 on the 257th frame.
    do_reset();
    d0 = done_cnt;
    for (int f = 0; f < 257; f++) begin
      spi_frame(8'h00, 8'h00, 16, 0, m0, m1, bad);
      ss_release();
      check($sformatf("wrap_f%0d_miso0", f), 32'(m0), 32'(f % 256));
    end
    check("wrap_done", 32'(done_cnt - d0), 32'd257);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
    $finish;
  end

endmodule
